// File: rtl/wait_state_mem.sv
// wait_state_mem: single-port WORDS x 32 memory shared by an instruction and a
// data channel, answering each access after LAT wait states (IDLE/WAIT/RESP).
// Data requests win arbitration; a request dropped during WAIT aborts it.
// Optional build macro MEM_ACCESS_COUNT_EN enables the icount/dcount hit
// counters; without it both outputs are tied to zero.
module wait_state_mem #(
  parameter int WORDS = 1024,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        busy,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  localparam int AW = $clog2(WORDS);
  localparam logic [3:0] LAT_C = 4'(LAT);
  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_ch;      // 1 = data channel owns the access
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic [31:0] r_mem [WORDS];

  logic        w_dreq;
  logic        w_any;
  logic        w_idle;
  logic        w_sel_ch;
  logic        w_sel_wr;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_ch_req;
  logic        w_access;
  logic        w_oor;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_dreq = dREN | dWEN;
  assign w_any  = w_dreq | iREN;
  assign w_idle = (r_state == S_IDLE);

  // With LAT=0 the access happens straight out of IDLE, so the access
  // operands come from the live inputs there and from the latch otherwise.
  assign w_sel_ch    = w_idle ? w_dreq : r_ch;
  assign w_sel_wr    = w_idle ? dWEN : r_wr;
  assign w_sel_addr  = w_idle ? (w_dreq ? daddr : iaddr) : r_addr;
  assign w_sel_wdata = w_idle ? dstore : r_wdata;

  // The owning channel must keep its request up through the wait states.
  assign w_ch_req = r_ch ? w_dreq : iREN;

  assign w_access = nRST &
                    ((w_idle & w_any & (LAT == 0)) |
                     ((r_state == S_WAIT) & w_ch_req & (r_cnt == 4'd1)));

  assign w_oor   = |w_sel_addr[31:AW+2];
  assign w_idx   = w_sel_addr[AW+1:2];
  assign w_rdata = w_oor ? BAD_WORD : r_mem[w_idx];

  // Byte-offset bits are deliberately ignored.
  assign w_unused = ^{w_sel_addr[1:0]};

  // Access FSM: latch in IDLE, count down in WAIT, present the hit in RESP.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ch    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ch    <= w_dreq;
            r_wr    <= dWEN;
            r_addr  <= w_dreq ? daddr : iaddr;
            r_wdata <= dstore;
            r_cnt   <= LAT_C;
            r_state <= (LAT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_ch_req) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data registers capture the array on the edge into RESP and hold.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_iload <= 32'd0;
      r_dload <= 32'd0;
    end else if (w_access && !w_sel_wr) begin
      if (w_sel_ch) r_dload <= w_rdata;
      else          r_iload <= w_rdata;
    end
  end

  // Array write on the edge into RESP; out-of-range writes are dropped.
  always_ff @(posedge CLK) begin
    if (w_access && w_sel_wr && !w_oor)
      r_mem[w_idx] <= w_sel_wdata;
  end

  assign iload = r_iload;
  assign dload = r_dload;
  assign ihit  = (r_state == S_RESP) & ~r_ch;
  assign dhit  = (r_state == S_RESP) &  r_ch;
  assign busy  = ~w_idle;

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;

  // Completed-access counters, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_icount <= 32'd0;
      r_dcount <= 32'd0;
    end else begin
      if (ihit) r_icount <= r_icount + 32'd1;
      if (dhit) r_dcount <= r_dcount + 32'd1;
    end
  end

  assign icount = r_icount;
  assign dcount = r_dcount;
`else
  assign icount = 32'd0;
  assign dcount = 32'd0;
`endif

endmodule

// File: tb/tb_wait_state_mem.sv
// Bench for wait_state_mem: four instances with LAT=0..3 share one stimulus
// stream; a transaction-timeline model per instance predicts every output.
module tb_wait_state_mem;
  localparam int TW = 64;
  localparam int NI = 4;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload [NI];
  logic [31:0] dload [NI];
  logic [31:0] icount [NI];
  logic [31:0] dcount [NI];
  logic        ihit [NI];
  logic        dhit [NI];
  logic        busy [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wait_state_mem #(.WORDS(TW), .LAT(g)) u_dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload[g]), .ihit(ihit[g]),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload[g]), .dhit(dhit[g]), .busy(busy[g]),
      .icount(icount[g]), .dcount(dcount[g])
    );
  end

  always #5 CLK = ~CLK;

  // ---------------- reference model (timeline of one transaction) ---------
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          m_fl [NI];
  int          m_tacc [NI];
  bit          m_ch [NI];
  bit          m_wr [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_wd [NI];
  logic [31:0] m_mem [NI][TW];
  bit          m_mv [NI][TW];
  logic [31:0] m_il [NI];
  logic [31:0] m_dl [NI];
  bit          m_ilk [NI];
  bit          m_dlk [NI];
  logic [31:0] m_ic [NI];
  logic [31:0] m_dc [NI];

  function automatic void m_access(input int k);
    logic [29:0] w;
    logic [31:0] v;
    bit kn;
    w = m_addr[k][31:2];
    if (m_wr[k]) begin
      if (w < TW) begin
        m_mem[k][w] = m_wd[k];
        m_mv[k][w]  = 1'b1;
      end
    end else begin
      if (w >= TW) begin v = BAD; kn = 1'b1; end
      else begin v = m_mem[k][w]; kn = m_mv[k][w]; end
      if (m_ch[k]) begin m_dl[k] = v; m_dlk[k] = kn; end
      else         begin m_il[k] = v; m_ilk[k] = kn; end
    end
  endfunction

  // Each instance k accepts at cycle t, does its access at the end of cycle
  // t+k, hits in cycle t+k+1, and is idle again the cycle after.
  always @(posedge CLK) begin
    if (!nRST) armed <= 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (!nRST) begin
        m_fl[k] = 1'b0;
        m_il[k] = '0; m_dl[k] = '0; m_ilk[k] = 1'b1; m_dlk[k] = 1'b1;
        m_ic[k] = '0; m_dc[k] = '0;
      end else if (m_fl[k] && cyc == m_tacc[k] + k + 1) begin
        m_fl[k] = 1'b0;
`ifdef MEM_ACCESS_COUNT_EN
        if (m_ch[k]) m_dc[k] = m_dc[k] + 32'd1;
        else         m_ic[k] = m_ic[k] + 32'd1;
`endif
      end else if (m_fl[k]) begin
        if (!(m_ch[k] ? (dREN | dWEN) : iREN)) m_fl[k] = 1'b0;
        else if (cyc == m_tacc[k] + k) m_access(k);
      end else if (dREN | dWEN | iREN) begin
        m_fl[k]   = 1'b1;
        m_tacc[k] = cyc;
        m_ch[k]   = dREN | dWEN;
        m_wr[k]   = dWEN;
        m_addr[k] = (dREN | dWEN) ? daddr : iaddr;
        m_wd[k]   = dstore;
        if (k == 0) m_access(k);
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- checking ---------------------------------------------
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_cycle();
    bit eh;
    if (!armed) return;
    for (int k = 0; k < NI; k++) begin
      eh = m_fl[k] && (cyc == m_tacc[k] + k + 1);
      chk($sformatf("ihit[%0d]", k), 32'(ihit[k]), 32'(eh && !m_ch[k]));
      chk($sformatf("dhit[%0d]", k), 32'(dhit[k]), 32'(eh && m_ch[k]));
      chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_fl[k]));
      if (m_ilk[k]) chk($sformatf("iload[%0d]", k), iload[k], m_il[k]);
      if (m_dlk[k]) chk($sformatf("dload[%0d]", k), dload[k], m_dl[k]);
      chk($sformatf("icount[%0d]", k), icount[k], m_ic[k]);
      chk($sformatf("dcount[%0d]", k), dcount[k], m_dc[k]);
    end
  endtask

  // Every wait in the bench goes through here, so outputs are compared each cycle.
  task automatic tick();
    @(negedge CLK);
    cmp_cycle();
  endtask

  task automatic quiesce();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (3) tick();
  endtask

  // Hold a write until every instance has completed it at least once.
  task automatic write_all(input logic [31:0] a, input logic [31:0] d);
    bit seen [NI];
    bit all;
    quiesce();
    dWEN = 1'b1; daddr = a; dstore = d;
    all = 1'b0;
    for (int i = 0; i < 60 && !all; i++) begin
      tick();
      all = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (dhit[k]) seen[k] = 1'b1;
        all = all & seen[k];
      end
    end
    dWEN = 1'b0;
    chk("write_all completion", 32'(all), 32'd1);
  endtask

  // One access aimed at instance k; returns negedges from issue to its hit.
  task automatic op(input int k, input bit isd, input bit wr, input logic [31:0] a,
                    input logic [31:0] d, output int n, output logic [31:0] ld);
    quiesce();
    if (isd) begin dREN = !wr; dWEN = wr; daddr = a; dstore = d; end
    else begin iREN = 1'b1; iaddr = a; end
    n = -1; ld = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (isd ? dhit[k] : ihit[k]) begin
        n = i; ld = isd ? dload[k] : iload[k];
        break;
      end
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  initial begin
    int n, dn, in_;
    logic [31:0] ld;
    logic [31:0] ea;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    tick(); tick();
    nRST = 1'b1;
    tick();
    chk("reset busy", 32'(busy[2]), 32'd0);
    chk("reset iload", iload[2], 32'd0);
    chk("reset dload", dload[2], 32'd0);

    write_all(32'h20, 32'h11112222);
    write_all(32'h30, 32'h33334444);
    write_all(32'h00, 32'h000000A0);
    write_all(32'h04, 32'h000000A4);
    write_all(32'h08, 32'h000000A8);

    // LAT=2 write then read of 0x10
    op(2, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, n, ld);
    chk("lat2 write latency", n, 3);
    op(2, 1'b0, 1'b0, 32'h10, 32'h0, n, ld);
    chk("lat2 read latency", n, 3);
    chk("lat2 read data", ld, 32'hDEADBEEF);

    // LAT=0 streaming instruction reads
    quiesce();
    iREN = 1'b1; iaddr = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("lat0 ihit pattern", 32'(ihit[0]), 32'(i % 2));
      chk("lat0 busy pattern", 32'(busy[0]), 32'(i % 2));
      if (i == 1) begin chk("lat0 iload 0", iload[0], 32'hA0); iaddr = 32'h4; end
      if (i == 3) begin chk("lat0 iload 4", iload[0], 32'hA4); iaddr = 32'h8; end
      if (i == 5) chk("lat0 iload 8", iload[0], 32'hA8);
    end

    // LAT=1 simultaneous requests: data first, then instruction
    quiesce();
    iREN = 1'b1; iaddr = 32'h10; dREN = 1'b1; daddr = 32'h20;
    dn = -1; in_ = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("lat1 never both hits", 32'(ihit[1] & dhit[1]), 32'd0);
      if (dhit[1] && dn < 0) begin dn = i; dREN = 1'b0; end
      if (ihit[1] && in_ < 0) in_ = i;
    end
    chk("lat1 dhit cycle", dn, 2);
    chk("lat1 ihit cycle", in_, 5);
    chk("lat1 dload", dload[1], 32'h11112222);

    // LAT=3 write aborted in WAIT
    quiesce();
    dWEN = 1'b1; daddr = 32'h20; dstore = 32'h55555555;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("lat3 abort no dhit", 32'(dhit[3]), 32'd0);
      if (i == 2) dWEN = 1'b0;
    end
    op(3, 1'b1, 1'b0, 32'h20, 32'h0, n, ld);
    chk("lat3 abort old value", ld, 32'h11112222);

    // LAT=3 reset during WAIT of a write
    quiesce();
    dWEN = 1'b1; daddr = 32'h30; dstore = 32'h99999999;
    tick();
    nRST = 1'b0;
    tick();
    chk("rst busy", 32'(busy[3]), 32'd0);
    chk("rst ihit", 32'(ihit[3]), 32'd0);
    chk("rst dhit", 32'(dhit[3]), 32'd0);
    chk("rst iload", iload[3], 32'd0);
    chk("rst dload", dload[3], 32'd0);
    chk("rst icount", icount[3], 32'd0);
    chk("rst dcount", dcount[3], 32'd0);
    nRST = 1'b1; dWEN = 1'b0;
    op(3, 1'b1, 1'b0, 32'h30, 32'h0, n, ld);
    chk("rst write discarded", ld, 32'h33334444);

    // Counters: 5 instruction and 3 data hits on LAT=3 after a reset
    nRST = 1'b0; tick(); nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op(3, 1'b0, 1'b0, 32'(i * 4), 32'h0, n, ld);
      chk("cnt ilat", n, 4);
    end
    op(3, 1'b1, 1'b0, 32'(TW * 4), 32'h0, n, ld);
    chk("oor dload", ld, BAD);
    op(3, 1'b1, 1'b1, 32'(TW * 4 + 8), 32'h12345678, n, ld);
    op(3, 1'b1, 1'b0, 32'h0000_0003, 32'h0, n, ld);
    chk("unaligned read word 0", ld, 32'hA0);
    quiesce();
`ifdef MEM_ACCESS_COUNT_EN
    ea = 32'd5;
`else
    ea = 32'd0;
`endif
    chk("icount after 5 ihits", icount[3], ea);
    chk("dcount after 3 dhits", dcount[3], ea == 0 ? 32'd0 : 32'd3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      nRST = ($urandom_range(299) != 0);
      if ($urandom_range(7) == 0) begin
        iREN  = $urandom_range(1);
        iaddr = $urandom_range((TW + 4) * 4 - 1);
        if ($urandom_range(15) == 0) iaddr = iaddr | 32'h1000_0000;
      end
      if ($urandom_range(7) == 0) begin
        dREN   = $urandom_range(1);
        dWEN   = ($urandom_range(2) == 0);
        daddr  = $urandom_range((TW + 4) * 4 - 1);
        dstore = $urandom;
      end
    end
    nRST = 1'b1;
    quiesce();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
